// File: rtl/pipe_pkg.sv
// Shared types and default widths for the decode-to-execute skid register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int unsigned PIPE_DATA_W = 152;
  localparam int unsigned PIPE_CTRL_W = 9;

endpackage

// File: rtl/pipe_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between decode and execute; flush kills both entries.
// Optional stall/flush statistics counters are built when PIPE_SKID_STATS_EN is defined.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Keeps only the non-control LSBs; the shift also covers CTRL_W == DATA_W.
  localparam logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b1}} >> CTRL_W;

  if ((CTRL_W == 0) || (CTRL_W > DATA_W) || (CNT_W == 0)) begin : g_bad_param
    $error("pipe_skid_reg: illegal DATA_W/CTRL_W/CNT_W combination");
  end

  skid_state_e       state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_xfer;
  logic              out_xfer;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      main_q  <= main_q & KEEP_MASK;
      skid_q  <= skid_q & KEEP_MASK;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_q  <= in_data;
            state_q <= ONE;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              skid_q  <= in_data;
              state_q <= FULL;
            end
            2'b01: state_q <= EMPTY;
            2'b11: main_q <= in_data;
            default: ;
          endcase
        end
        FULL: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_SKID_STATS_EN
  // A flush only counts when it actually throws away a valid entry.
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush && (state_q != EMPTY)),
    .count (flush_cnt)
  );
`endif

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 152, meaning payload width in bits (full decode-to-execute bundle).
REQ-002 SHALL have parameter CTRL_W, default 9, meaning number of payload MSBs that are control bits (wb_en, mem_r_en, mem_w_en, b, s, exe_cmd); 0 < CTRL_W <= DATA_W.
REQ-003 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-004 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous pipeline kill (branch taken).
REQ-007 SHALL have port in_valid  input  1  upstream holds a valid bundle.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port in_data  input  DATA_W  upstream bundle.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid bundle.
REQ-011 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-012 SHALL have port out_data  output  DATA_W  registered bundle to execute stage.
REQ-013 SHALL have, only under PIPE_SKID_STATS_EN, ports stall_cnt and flush_cnt  output  CNT_W  each  event counters.

Function
REQ-014 SHALL be a two-entry skid buffer (main register driving out_data, skid register behind it) with states EMPTY, ONE, FULL.
REQ-015 SHALL count an input transfer as in_valid && in_ready and an output transfer as out_valid && out_ready, both sampled at rising clk.
REQ-016 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), both purely from registered state.
REQ-017 SHALL transition EMPTY -> ONE on input transfer, loading main.
REQ-018 SHALL, in ONE: with input only, go to FULL loading skid; with output only, go to EMPTY; with both, stay ONE loading main from in_data.
REQ-019 SHALL, in FULL, on output transfer go to ONE with main <= skid; otherwise hold.
REQ-020 SHALL preserve order, never drop or duplicate a bundle, and keep out_data stable while out_valid && !out_ready.
REQ-021 SHALL give one-cycle latency: a bundle accepted at edge N appears on out_data with out_valid after edge N when the buffer was EMPTY.
REQ-022 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-023 SHALL, on flush at an edge, go to EMPTY, discard both entries and any simultaneous input transfer, and clear the CTRL_W MSBs of main and skid; flush has priority over every transfer.
REQ-024 SHALL leave the non-control payload bits of cleared entries unchanged on flush (don't-care, not zeroed).

Reset
REQ-025 SHALL, while rst_n is low, asynchronously force state EMPTY, main and skid all-zero, out_valid 0, in_ready 1 and counters 0.
REQ-026 SHALL lose any bundle in flight when reset asserts mid-operation, and SHALL accept input at the first rising clk after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro PIPE_SKID_STATS_EN defined, increment stall_cnt on each cycle with out_valid && !out_ready, and increment flush_cnt on each flush cycle that discards at least one valid entry; both counters saturate at all-ones.
REQ-028 SHALL, without PIPE_SKID_STATS_EN, omit the counter ports and logic entirely, with identical datapath behaviour.

Structure
REQ-029 SHALL take the state enum (EMPTY, ONE, FULL) and default DATA_W and CTRL_W constants from shared package pipe_pkg.
REQ-030 SHALL implement each statistics counter as an instance of sub-module pipe_sat_counter (parameter CNT_W, ports clk, rst_n, inc, count).

Verification
REQ-031 SHALL cover the following scenario: reset, then in_data=152'hA5 with in_valid=1 and out_ready=1 -> out_valid=1 and out_data=152'hA5 after one edge.
REQ-032 SHALL cover the following scenario: 3 back-to-back inputs 1,2,3 with out_ready=0 -> in_ready drops after 2 are accepted, and out_data holds 1; then out_ready=1 -> outputs 1,2,3 in order with no gaps.
REQ-033 SHALL cover the following scenario: FULL state plus flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, control MSBs of out_data zero, and the input is not delivered.
REQ-034 SHALL cover the following scenario: 1000 random in_valid/out_ready cycles at 50% each -> scoreboard shows exact order and no loss.
REQ-035 SHALL cover the following scenario: rst_n pulsed low between edges while FULL -> out_valid=0 immediately, without waiting for clk.
REQ-036 SHALL cover the following scenario, with PIPE_SKID_STATS_EN and CNT_W=4: 20 stall cycles -> stall_cnt=15 (saturated), and 2 flushes of valid entries -> flush_cnt=2.
